rf_writeback_arbiter: RTL and testbench
=======================================

RF_WRITEBACK_ARBITER -- requirements
Module: rf_writeback_arbiter

Interface
REQ-001 SHALL have parameter LD_DEPTH, default 2, giving the load-result FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_MAX, default 3, giving the maximum consecutive lost arbitrations before the load source wins.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 alu_valid  in  1  ALU writeback request.
REQ-007 alu_ready  out  1  ALU request accepted on this edge when high with alu_valid.
REQ-008 alu_rd  in  5  ALU destination register.
REQ-009 alu_data  in  32  ALU result.
REQ-010 ld_valid  in  1  load-unit writeback request.
REQ-011 ld_ready  out  1  load request accepted on this edge when high with ld_valid.
REQ-012 ld_rd  in  5  load destination register.
REQ-013 ld_data  in  32  load result.
REQ-014 rf_we  out  1  register-file write enable, registered.
REQ-015 rf_rd_addr  out  5  register-file write address, registered.
REQ-016 rf_write_data  out  32  register-file write data, registered.
REQ-017 pending_mask  out  32  bit r set while any accepted, unwritten entry targets register r; bit 0 always 0.

Function
REQ-018 ALU path SHALL hold one entry; alu_ready = hold empty OR hold granted this cycle.
REQ-019 Load path SHALL be a FIFO of LD_DEPTH entries; ld_ready = NOT full; no pass-through when full, even if popped in the same cycle.
REQ-020 Each cycle the arbiter SHALL grant at most one stored entry: ALU if only ALU is valid, load if only load is valid.
REQ-021 When both are valid, ALU SHALL win unless starve_cnt == STARVE_MAX, in which case load wins.
REQ-022 starve_cnt SHALL increment (saturating at STARVE_MAX) when load loses, clear to 0 when load is granted, and hold otherwise.
REQ-023 A granted entry SHALL drive rf_we=1, rf_rd_addr, rf_write_data for exactly the cycle after the grant edge; otherwise rf_we=0 and addr/data hold their last value.
REQ-024 Latency SHALL be one cycle: an entry accepted at edge E and granted uncontended appears on rf_we from edge E+1.
REQ-025 A granted entry with rd==0 SHALL be consumed with rf_we=0 (x0 never written).
REQ-026 Outputs SHALL change only on the rising edge, so the register file (which writes on the falling edge) samples stable values mid-cycle.
REQ-027 pending_mask SHALL be the OR of decoded rd of all occupied ALU-hold and FIFO entries, combinational from state.
REQ-028 Two pending entries to the same rd SHALL both be written, in acceptance order within a source; cross-source order follows arbitration.
REQ-029 FIFO pointers SHALL wrap modulo LD_DEPTH, with an explicit count used for full/empty.

Reset
REQ-030 rst SHALL clear the ALU hold, FIFO count/pointers, and starve_cnt, set rf_we=0, rf_rd_addr=0, rf_write_data=0; alu_ready=1, ld_ready=1, pending_mask=0 in the cycle after reset.
REQ-031 rst asserted mid-operation SHALL discard all queued entries without any further rf_we pulse; rst has priority over every handshake in the same cycle.

Structure
REQ-032 Shared package SHALL define REG_ADDR_W=5, XLEN=32, and a wb_entry_t struct {rd, data}.
REQ-033 Load FIFO SHALL be a sub-module wb_fifo (parameterized depth, push/pop/full/empty/count).

Verification
REQ-034 ALU only: alu_valid, rd=5, data=0xDEADBEEF at edge E -> rf_we=1, addr 5, data 0xDEADBEEF during E+1; pending_mask bit5 set for one cycle.
REQ-035 Contention: ALU valid every cycle, 4 loads queued, STARVE_MAX=3 -> ALU wins 3 grants, then load wins, then the pattern repeats.
REQ-036 FIFO full: 2 loads queued, no grants (ALU saturating) -> ld_ready=0; third load stalls until a pop, and is accepted only the edge after ld_ready returns to 1.
REQ-037 x0: load rd=0, data=0x1234 -> entry consumed, rf_we stays 0, ld_ready recovers.
REQ-038 Reset mid-flight: 1 ALU and 2 load entries pending, assert rst for one cycle -> no rf_we, pending_mask=0, ready=1 afterwards.
REQ-039 Ordering: loads rd=7 with data=1, then rd=7 with data=2 -> writes observed as 1 then 2.

Source files
------------

// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_writeback_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    // One pending writeback: destination register and result.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // Which stored source, if any, owns the write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LD   = 2'd2
    } grant_e;

    // Decode a destination register into a one-hot register mask.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        rd_onehot = NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Writeback request/response bundle between the execution units and the arbiter.
interface rf_writeback_arbiter_if;
    import rf_writeback_arbiter_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd_addr;
    logic [XLEN-1:0]       rf_write_data;
    logic [NUM_REGS-1:0]   pending_mask;

    // Requesting side: execution units and register-file observer.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready,
        input  rf_we, rf_rd_addr, rf_write_data, pending_mask
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready,
        output rf_we, rf_rd_addr, rf_write_data, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// Small FIFO of writeback entries with an occupancy-based register mask.
module wb_fifo
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    push_data,
    output wb_entry_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [NUM_REGS-1:0]          rd_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] mask_idx_c;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign push_ok_c = push && !full;
    assign pop_ok_c  = pop && !empty;

    // Pointer and count update; pointers wrap explicitly at DEPTH-1.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok_c && !pop_ok_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; validity is tracked by the count, so no reset needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // OR of destination registers across the occupied slots.
    always_comb begin
        rd_mask    = '0;
        mask_idx_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mask_idx_c = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                rd_mask = rd_mask | rd_onehot(mem_q[mask_idx_c].rd);
            end
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int unsigned LD_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    rf_writeback_arbiter_if.slave        bus
);

    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned LD_CNT_W = $clog2(LD_DEPTH + 1);

    logic                  alu_hold_valid_q, alu_hold_valid_d;
    wb_entry_t             alu_hold_q, alu_hold_d;
    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
    logic [XLEN-1:0]       rf_write_data_q, rf_write_data_d;

    grant_e                grant_c;
    wb_entry_t             win_c;
    wb_entry_t             ld_in_c;
    wb_entry_t             ld_head_c;
    logic                  ld_full_c;
    logic                  ld_empty_c;
    logic [LD_CNT_W-1:0]   ld_count_c;
    logic [NUM_REGS-1:0]   ld_mask_c;
    logic                  alu_ready_c;
    logic                  ld_ready_c;
    logic                  alu_push_c;
    logic                  ld_push_c;
    logic                  ld_pop_c;

    assign ld_in_c.rd   = bus.ld_rd;
    assign ld_in_c.data = bus.ld_data;

    // Load results queue here until they win the write port.
    wb_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ld_push_c),
        .pop       (ld_pop_c),
        .push_data (ld_in_c),
        .head      (ld_head_c),
        .full      (ld_full_c),
        .empty     (ld_empty_c),
        .count     (ld_count_c),
        .rd_mask   (ld_mask_c)
    );

    // Pick one stored entry: ALU by default, load once it has starved long enough.
    always_comb begin
        grant_c = GRANT_NONE;
        if (alu_hold_valid_q && !ld_empty_c) begin
            grant_c = (starve_cnt_q == STARVE_W'(STARVE_MAX)) ? GRANT_LD : GRANT_ALU;
        end else if (alu_hold_valid_q) begin
            grant_c = GRANT_ALU;
        end else if (!ld_empty_c) begin
            grant_c = GRANT_LD;
        end
    end

    // ALU hold refills in the cycle it drains; the load FIFO never passes through when full.
    assign alu_ready_c = !alu_hold_valid_q || (grant_c == GRANT_ALU);
    assign ld_ready_c  = !ld_full_c;
    assign alu_push_c  = bus.alu_valid && alu_ready_c;
    assign ld_push_c   = bus.ld_valid && ld_ready_c;
    assign ld_pop_c    = (grant_c == GRANT_LD);
    assign win_c       = (grant_c == GRANT_LD) ? ld_head_c : alu_hold_q;

    // Next-state for the ALU hold, starvation counter and write-port outputs.
    always_comb begin
        alu_hold_valid_d = alu_hold_valid_q;
        alu_hold_d       = alu_hold_q;
        starve_cnt_d     = starve_cnt_q;
        rf_we_d          = 1'b0;
        rf_rd_addr_d     = rf_rd_addr_q;
        rf_write_data_d  = rf_write_data_q;

        if (alu_push_c) begin
            alu_hold_valid_d = 1'b1;
            alu_hold_d.rd    = bus.alu_rd;
            alu_hold_d.data  = bus.alu_data;
        end else if (grant_c == GRANT_ALU) begin
            alu_hold_valid_d = 1'b0;
        end

        if (grant_c == GRANT_LD) begin
            starve_cnt_d = '0;
        end else if ((grant_c == GRANT_ALU) && !ld_empty_c &&
                     (starve_cnt_q != STARVE_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end

        // x0 writes are consumed silently; address and data keep their last value.
        if ((grant_c != GRANT_NONE) && (win_c.rd != '0)) begin
            rf_we_d         = 1'b1;
            rf_rd_addr_d    = win_c.rd;
            rf_write_data_d = win_c.data;
        end
    end

    // State register; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_hold_valid_q <= 1'b0;
            alu_hold_q       <= '0;
            starve_cnt_q     <= '0;
            rf_we_q          <= 1'b0;
            rf_rd_addr_q     <= '0;
            rf_write_data_q  <= '0;
        end else begin
            alu_hold_valid_q <= alu_hold_valid_d;
            alu_hold_q       <= alu_hold_d;
            starve_cnt_q     <= starve_cnt_d;
            rf_we_q          <= rf_we_d;
            rf_rd_addr_q     <= rf_rd_addr_d;
            rf_write_data_q  <= rf_write_data_d;
        end
    end

    assign bus.alu_ready     = alu_ready_c;
    assign bus.ld_ready      = ld_ready_c;
    assign bus.rf_we         = rf_we_q;
    assign bus.rf_rd_addr    = rf_rd_addr_q;
    assign bus.rf_write_data = rf_write_data_q;
    assign bus.pending_mask  = ((alu_hold_valid_q ? rd_onehot(alu_hold_q.rd) : '0) | ld_mask_c)
                               & ~NUM_REGS'(1);

    // FIFO occupancy can never exceed its depth.
    a_ld_count_range: assert property (@(posedge clk) disable iff (rst)
        ld_count_c <= LD_CNT_W'(LD_DEPTH));

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench: tests push expected writebacks, a monitor pops on every rf_we.
module tb_rf_writeback_arbiter;
    import rf_writeback_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    wb_entry_t exp_q [$];

    always #5 clk = ~clk;

    rf_writeback_arbiter_if bus ();

    rf_writeback_arbiter #(
        .LD_DEPTH   (2),
        .STARVE_MAX (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic wb_entry_t mk(input logic [4:0] rd, input logic [31:0] d);
        mk.rd   = rd;
        mk.data = d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.ld_valid = v;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
    endtask

    task automatic idle();
        set_alu(1'b0, 5'd0, 32'd0);
        set_ld(1'b0, 5'd0, 32'd0);
    endtask

    // Wait (bounded) until every expected writeback has been observed.
    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ALU offered every cycle against four loads; grants go A A A L repeatedly.
    task automatic run_contention(input string tag);
        logic alu_rdy_tab [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
        logic ld_rdy_tab  [11] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        int   order       [12] = '{0, 1, 2, 100, 3, 4, 5, 101, 6, 7, 102, 103};
        int   ai = 0;
        int   li = 0;
        logic a_fire, l_fire;
        for (int k = 0; k < 12; k++) begin
            if (order[k] >= 100)
                exp_q.push_back(mk(5'(16 + order[k] - 100), 32'hB000_0000 + 32'(order[k] - 100)));
            else
                exp_q.push_back(mk(5'(1 + order[k]), 32'hA000_0000 + 32'(order[k])));
        end
        @(negedge clk);
        for (int c = 0; c < 11; c++) begin
            set_alu(ai < 8, 5'(1 + ai), 32'hA000_0000 + 32'(ai));
            set_ld(li < 4, 5'(16 + li), 32'hB000_0000 + 32'(li));
            check($sformatf("%s_alu_ready_c%0d", tag, c), 32'(bus.alu_ready), 32'(alu_rdy_tab[c]));
            check($sformatf("%s_ld_ready_c%0d", tag, c), 32'(bus.ld_ready), 32'(ld_rdy_tab[c]));
            a_fire = bus.alu_valid && bus.alu_ready;
            l_fire = bus.ld_valid && bus.ld_ready;
            @(negedge clk);
            if (a_fire) ai++;
            if (l_fire) li++;
        end
        idle();
        wait_drain(tag);
    endtask

    // Monitor: every write-port pulse must match the next expected writeback.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            if (bus.rf_we === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: got rd=%0d data=0x%08h, want no write",
                             bus.rf_rd_addr, bus.rf_write_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rf_rd_addr !== e.rd || bus.rf_write_data !== e.data) begin
                        n_errors++;
                        $display("FAIL wb_entry: got rd=%0d data=0x%08h, want rd=%0d data=0x%08h",
                                 bus.rf_rd_addr, bus.rf_write_data, e.rd, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rf_addr", 32'(bus.rf_rd_addr), 32'd0);
        check("rst_rf_data", bus.rf_write_data, 32'd0);
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_pending", bus.pending_mask, 32'd0);

        // ALU only: one-cycle latency, pending for one cycle, outputs hold afterwards
        @(negedge clk);
        set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        exp_q.push_back(mk(5'd5, 32'hDEAD_BEEF));
        check("alu_ready_idle", 32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        idle();
        check("alu_pending_bit5", bus.pending_mask, 32'h0000_0020);
        check("alu_we_before_grant", 32'(bus.rf_we), 32'd0);
        @(negedge clk);
        check("alu_we_after_grant", 32'(bus.rf_we), 32'd1);
        check("alu_pending_cleared", bus.pending_mask, 32'd0);
        @(negedge clk);
        check("alu_we_single_pulse", 32'(bus.rf_we), 32'd0);
        check("alu_addr_hold", 32'(bus.rf_rd_addr), 32'd5);
        check("alu_data_hold", bus.rf_write_data, 32'hDEAD_BEEF);

        // x0 load: consumed without a write, queue drains
        @(negedge clk);
        set_ld(1'b1, 5'd0, 32'h0000_1234);
        check("x0_ld_ready", 32'(bus.ld_ready), 32'd1);
        @(negedge clk);
        idle();
        check("x0_pending_zero", bus.pending_mask, 32'd0);
        check("x0_ld_ready_one_queued", 32'(bus.ld_ready), 32'd1);
        @(negedge clk);
        check("x0_no_we", 32'(bus.rf_we), 32'd0);
        check("x0_addr_hold", 32'(bus.rf_rd_addr), 32'd5);
        check("x0_ld_ready_recovered", 32'(bus.ld_ready), 32'd1);
        set_ld(1'b1, 5'd3, 32'h0000_0033);
        exp_q.push_back(mk(5'd3, 32'h0000_0033));
        @(negedge clk);
        idle();
        @(negedge clk);
        check("x0_followup_latency", 32'(bus.rf_we), 32'd1);

        // Same-register ordering within the load source
        @(negedge clk);
        set_ld(1'b1, 5'd7, 32'd1);
        exp_q.push_back(mk(5'd7, 32'd1));
        check("ord_ld_ready_first", 32'(bus.ld_ready), 32'd1);
        @(negedge clk);
        set_ld(1'b1, 5'd7, 32'd2);
        exp_q.push_back(mk(5'd7, 32'd2));
        check("ord_ld_ready_second", 32'(bus.ld_ready), 32'd1);
        check("ord_pending_bit7", bus.pending_mask, 32'h0000_0080);
        @(negedge clk);
        idle();
        wait_drain("ord");

        // Contention and FIFO-full back-pressure
        run_contention("cont1");

        // Reset mid-flight: one ALU and two loads pending, rst beats live handshakes
        @(negedge clk);
        set_alu(1'b1, 5'd9, 32'h0000_00C0);
        set_ld(1'b1, 5'd11, 32'h0000_00C1);
        exp_q.push_back(mk(5'd9, 32'h0000_00C0));
        @(negedge clk);
        set_alu(1'b1, 5'd10, 32'h0000_00C2);
        set_ld(1'b1, 5'd12, 32'h0000_00C3);
        @(negedge clk);
        check("rstmid_pending_before", bus.pending_mask, 32'h0000_1C00);
        rst = 1'b1;
        set_alu(1'b1, 5'd13, 32'h0000_00C4);
        set_ld(1'b1, 5'd14, 32'h0000_00C5);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("rstmid_no_we", 32'(bus.rf_we), 32'd0);
        check("rstmid_pending_zero", bus.pending_mask, 32'd0);
        check("rstmid_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("rstmid_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rstmid_addr_zero", 32'(bus.rf_rd_addr), 32'd0);
        check("rstmid_data_zero", bus.rf_write_data, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("rstmid_no_leftover", 32'(exp_q.size()), 32'd0);
        check("rstmid_quiet_pending", bus.pending_mask, 32'd0);

        // Starvation counter restarts from zero after reset
        run_contention("cont2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
